// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate D-cache.
// Mem-stage side dcache_*, bus side mem_* (req/ack), hit/miss counters.
module dcache_ctrl #(
  parameter int LINES = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dcache_en,
  input  logic             dcache_wren,
  input  logic [63:0]      dcache_addr,
  input  logic [63:0]      dcache_wdata,
  output logic [63:0]      dcache_rdata,
  output logic             dcache_done,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_wren,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 64 - IDX - 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [63:3]      addr_q, addr_d;
  logic             wren_q, wren_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TW-1:0]    tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  logic [IDX-1:0]   idx;
  logic [TW-1:0]    tag;
  logic             hit;
  logic             line_we;
  logic [63:0]      line_wdata;
  logic             unused_addr;

  assign unused_addr = ^dcache_addr[2:0];

  assign idx = addr_q[IDX+2:3];
  assign tag = addr_q[63:IDX+3];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign dcache_rdata = rdata_q;
  assign dcache_done  = done_q;
  assign mem_req      = req_q;
  assign mem_wren     = wren_q;
  assign mem_addr     = {addr_q, 3'b000};
  assign mem_wdata    = wdata_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    req_d      = req_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    valid_d    = valid_q;
    line_we    = 1'b0;
    line_wdata = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (dcache_en) begin
          addr_d  = dcache_addr[63:3];
          wren_d  = dcache_wren;
          wdata_d = dcache_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (hit_q != '1) hit_d = hit_q + 1'b1;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
        end
        if (!wren_q && hit) begin
          rdata_d = data_mem[idx];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          req_d   = 1'b1;
          line_we = wren_q && hit;
          state_d = wren_q ? S_MEM_WR : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          line_we      = 1'b1;
          line_wdata   = mem_rdata;
          valid_d[idx] = 1'b1;
          rdata_d      = mem_rdata;
          done_d       = 1'b1;
          req_d        = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          done_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      req_q   <= req_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[idx] <= line_wdata;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed checks of dcache_ctrl.
// Small counters (CNT_W=3) so saturation is reachable.
module tb_dcache_ctrl;

  localparam int LINES = 64;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          wren = 1'b0;
  logic [63:0]   addr = '0;
  logic [63:0]   wdata = '0;
  logic [63:0]   dcache_rdata;
  logic          dcache_done;
  logic          flush = 1'b0;
  logic          mem_req;
  logic          mem_wren;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] rd;
  logic [63:0] ba;
  logic [63:0] bd;
  logic        bw;
  logic        sreq;
  int          lat;
  int          ndone;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(LINES), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dcache_en    (en),
    .dcache_wren  (wren),
    .dcache_addr  (addr),
    .dcache_wdata (wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_done  (dcache_done),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; the bus acks dly samples after mem_req is seen.
  // stray: ack pulse in LOOKUP (mem_req=0). fb: flush held while busy.
  task automatic txn(input logic wr,
                     input logic [63:0] a,
                     input logic [63:0] d,
                     input int dly,
                     input logic [63:0] brd,
                     input logic stray,
                     input logic fb);
    logic acked;
    int   w;
    acked = 1'b0;
    w     = 0;
    lat   = 0;
    sreq  = 1'b0;
    ba    = '0;
    bd    = '0;
    bw    = 1'b0;
    @(negedge clk);
    en    = 1'b1;
    wren  = wr;
    addr  = a;
    wdata = d;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (k == 1) begin
        if (stray) begin
          mem_ack   = 1'b1;
          mem_rdata = 64'hBAD0BAD0;
        end
        if (fb) flush = 1'b1;
      end
      if (dcache_done) begin
        lat = k;
        rd  = dcache_rdata;
        break;
      end
      if (mem_req && !acked) begin
        if (!sreq) begin
          sreq = 1'b1;
          ba   = mem_addr;
          bw   = mem_wren;
          bd   = mem_wdata;
        end
        w++;
        if (w >= dly) begin
          mem_ack   = 1'b1;
          mem_rdata = brd;
          acked     = 1'b1;
        end
      end
    end
    en      = 1'b0;
    flush   = 1'b0;
    mem_ack = 1'b0;
    if (lat == 0) check("timeout", 1, 0);
    @(posedge clk);
    #1;
    check("pulse", {63'd0, dcache_done}, 0);
  endtask

  initial begin
    #12;
    check("rst_done", {63'd0, dcache_done}, 0);
    check("rst_req", {63'd0, mem_req}, 0);
    check("rst_rdata", dcache_rdata, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_cnt", {hit_count, miss_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: cold read miss
    txn(0, 64'h1000, 0, 3, 64'hDEADBEEF, 0, 0);
    check("t1_req", {63'd0, sreq}, 1);
    check("t1_bwren", {63'd0, bw}, 0);
    check("t1_baddr", ba, 64'h1000);
    check("t1_rdata", rd, 64'hDEADBEEF);
    check("t1_lat", lat, 5);
    check("t1_miss", miss_count, 1);
    check("t1_hit", hit_count, 0);

    // 2: read hit
    txn(0, 64'h1000, 0, 1, 0, 0, 0);
    check("t2_req", {63'd0, sreq}, 0);
    check("t2_lat", lat, 2);
    check("t2_rdata", rd, 64'hDEADBEEF);
    check("t2_hit", hit_count, 1);

    // 3: write hit then read
    txn(1, 64'h1000, 64'h55, 2, 0, 0, 0);
    check("t3_req", {63'd0, sreq}, 1);
    check("t3_bwren", {63'd0, bw}, 1);
    check("t3_bwdata", bd, 64'h55);
    check("t3_lat", lat, 4);
    check("t3_rdkeep", rd, 64'hDEADBEEF);
    check("t3_hit", hit_count, 2);
    txn(0, 64'h1000, 0, 1, 0, 0, 0);
    check("t3_rreq", {63'd0, sreq}, 0);
    check("t3_rdata", rd, 64'h55);
    check("t3_rhit", hit_count, 3);

    // 4: write miss does not allocate
    txn(1, 64'h2000, 64'h77, 1, 0, 0, 0);
    check("t4_wmiss", miss_count, 2);
    txn(0, 64'h2005, 0, 1, 64'h99, 1, 0);
    check("t4_req", {63'd0, sreq}, 1);
    check("t4_baddr", ba, 64'h2000);
    check("t4_rdata", rd, 64'h99);
    check("t4_lat", lat, 3);
    check("t4_miss", miss_count, 3);

    // 5: conflict eviction
    txn(0, 64'h1000 + 8 * LINES, 0, 2, 64'hAAAA, 0, 0);
    check("t5_req", {63'd0, sreq}, 1);
    check("t5_rdata", rd, 64'hAAAA);
    txn(0, 64'h1000, 0, 1, 64'hBBBB, 0, 0);
    check("t5_evict", {63'd0, sreq}, 1);
    check("t5_rdata2", rd, 64'hBBBB);
    check("t5_miss", miss_count, 5);

    // 6: flush in IDLE with a stray ack
    @(negedge clk);
    flush   = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    mem_ack = 1'b0;
    check("t6_fdone", {63'd0, dcache_done}, 0);
    check("t6_fcnt", {hit_count, miss_count}, {3'd3, 3'd5});
    txn(0, 64'h1000, 0, 1, 64'hCCCC, 0, 0);
    check("t6_req", {63'd0, sreq}, 1);
    check("t6_miss", miss_count, 6);
    txn(0, 64'h1000, 0, 1, 0, 0, 1);
    check("t6_busyfl", {63'd0, sreq}, 0);
    check("t6_rdata", rd, 64'hCCCC);
    check("t6_hit", hit_count, 4);

    // counter saturation
    for (int i = 0; i < 4; i++) txn(0, 64'h1000, 0, 1, 0, 0, 0);
    check("sat_hit", hit_count, 7);

    // reset during MEM_RD
    @(negedge clk);
    en   = 1'b1;
    wren = 1'b0;
    addr = 64'h3000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("r_req", {63'd0, mem_req}, 1);
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    check("r_done", {63'd0, dcache_done}, 0);
    check("r_mreq", {63'd0, mem_req}, 0);
    check("r_mwren", {63'd0, mem_wren}, 0);
    check("r_maddr", mem_addr, 0);
    check("r_mwdata", mem_wdata, 0);
    check("r_rdata", dcache_rdata, 0);
    check("r_cnt", {hit_count, miss_count}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone   = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (dcache_done) ndone++;
    end
    check("r_nodone", ndone, 0);
    txn(0, 64'h1000, 0, 1, 64'hDDDD, 0, 0);
    check("r_inval", {63'd0, sreq}, 1);
    check("r_rd", rd, 64'hDDDD);
    check("r_miss", miss_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
